// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg
// Shared types and constants for the UART frame scheduler.
//   sched_state_t     - scheduler FSM states
//   SYNC_BYTE_DEFAULT - first byte of every frame unless overridden
//   ID_W              - width of a requester index (supports up to 8 requesters)
package uart_sched_pkg;

    localparam int         ID_W              = 3;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND_SYNC = 3'd1,
        S_SEND_ID   = 3'd2,
        S_SEND_DATA = 3'd3,
        S_SEND_CSUM = 3'd4,
        S_WAIT_DONE = 3'd5
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts at index ptr and wraps
// modulo N; the first requesting index wins.
// Ports:
//   req     in  N     request vector
//   ptr     in  ID_W  highest-priority index this round (must be < N)
//   gnt     out N     one-hot grant (all zero when nothing requests)
//   gnt_idx out ID_W  index of the winner (0 when nothing requests)
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx
);

    localparam int REQ_W = 2 ** ID_W;

    // Padding to the full index range keeps every dynamic select in bounds.
    logic [REQ_W-1:0] req_pad;
    logic [ID_W-1:0]  cand_idx [N];
    logic [N-1:0]     cand_req;

    assign req_pad = REQ_W'(req);

    // cand_idx[gi] is the requester examined at priority rank gi.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [ID_W:0] sum;
        assign sum          = {1'b0, ptr} + (ID_W + 1)'(gi);
        assign cand_idx[gi] = (sum >= (ID_W + 1)'(N)) ? ID_W'(sum - (ID_W + 1)'(N))
                                                      : sum[ID_W-1:0];
        assign cand_req[gi] = req_pad[cand_idx[gi]];
    end

    always_comb begin
        logic found;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && cand_req[k]) begin
                found   = 1'b1;
                gnt_idx = cand_idx[k];
            end
        end
        if (found) begin
            gnt = N'(1) << gnt_idx;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one uart_tx serializer among NUM_REQ byte-stream requesters. A
// round-robin winner is locked for a whole frame: SYNC, ID, payload, XOR csum.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/data/last   per-requester payload stream (byte i at [8i+7:8i])
//   req_ready             one-hot pulse: granted requester's byte consumed
//   tx_start, tx_data     start pulse and byte to uart_tx
//   tx_busy, tx_done      status from uart_tx
//   active, grant_id      frame in progress and its requester
//   frame_done            pulse on the checksum byte's tx_done
//   len_err               pulse when a frame is cut at MAX_LEN
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         MAX_LEN   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 active,
    output logic [ID_W-1:0]      grant_id,
    output logic                 frame_done,
    output logic                 len_err
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int REQ_W = 2 ** ID_W;

    sched_state_t         state_reg, state_next, ret_reg, ret_next;
    logic [ID_W-1:0]      grant_reg, grant_next, ptr_reg, ptr_next;
    logic [7:0]           csum_reg, csum_next, tx_data_reg, tx_data_next;
    logic [LEN_W-1:0]     len_reg, len_next;
    logic                 ovf_reg, ovf_next;
    logic                 tx_start_reg, tx_start_next;
    logic [NUM_REQ-1:0]   req_ready_reg, req_ready_next;
    logic                 active_reg, active_next;
    logic                 frame_done_reg, frame_done_next;
    logic                 len_err_reg, len_err_next;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [ID_W-1:0]      arb_idx;
    logic [REQ_W-1:0]     valid_pad, last_pad;
    logic [8*REQ_W-1:0]   data_pad;
    logic                 sel_valid, sel_last;
    logic [7:0]           sel_data, id_byte;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_reg),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Granted requester's stream; padded so the dynamic selects stay in range.
    assign valid_pad = REQ_W'(req_valid);
    assign last_pad  = REQ_W'(req_last);
    assign data_pad  = (8 * REQ_W)'(req_data);
    assign sel_valid = valid_pad[grant_reg];
    assign sel_last  = last_pad[grant_reg];
    assign sel_data  = data_pad[{grant_reg, 3'b000} +: 8];
    assign id_byte   = {{(8 - ID_W){1'b0}}, grant_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ret_reg        <= S_IDLE;
            grant_reg      <= '0;
            ptr_reg        <= '0;
            csum_reg       <= '0;
            len_reg        <= '0;
            ovf_reg        <= 1'b0;
            tx_start_reg   <= 1'b0;
            tx_data_reg    <= '0;
            req_ready_reg  <= '0;
            active_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            len_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ret_reg        <= ret_next;
            grant_reg      <= grant_next;
            ptr_reg        <= ptr_next;
            csum_reg       <= csum_next;
            len_reg        <= len_next;
            ovf_reg        <= ovf_next;
            tx_start_reg   <= tx_start_next;
            tx_data_reg    <= tx_data_next;
            req_ready_reg  <= req_ready_next;
            active_reg     <= active_next;
            frame_done_reg <= frame_done_next;
            len_err_reg    <= len_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ret_next        = ret_reg;
        grant_next      = grant_reg;
        ptr_next        = ptr_reg;
        csum_next       = csum_reg;
        len_next        = len_reg;
        ovf_next        = ovf_reg;
        tx_data_next    = tx_data_reg;
        active_next     = active_reg;
        tx_start_next   = 1'b0;
        req_ready_next  = '0;
        frame_done_next = 1'b0;
        len_err_next    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (|arb_gnt) begin
                    grant_next  = arb_idx;
                    csum_next   = '0;
                    len_next    = '0;
                    ovf_next    = 1'b0;
                    active_next = 1'b1;
                    // SYNC goes out in the same edge as the grant so the
                    // start pulse lines up with active; SEND_SYNC is only
                    // visited when the serializer is still busy.
                    if (!tx_busy) begin
                        tx_start_next = 1'b1;
                        tx_data_next  = SYNC_BYTE;
                        ret_next      = S_SEND_ID;
                        state_next    = S_WAIT_DONE;
                    end else begin
                        state_next    = S_SEND_SYNC;
                    end
                end
            end
            S_SEND_SYNC: begin
                if (!tx_busy) begin
                    tx_start_next = 1'b1;
                    tx_data_next  = SYNC_BYTE;
                    ret_next      = S_SEND_ID;
                    state_next    = S_WAIT_DONE;
                end
            end
            S_SEND_ID: begin
                if (!tx_busy) begin
                    tx_start_next = 1'b1;
                    tx_data_next  = id_byte;
                    csum_next     = csum_reg ^ id_byte;
                    ret_next      = S_SEND_DATA;
                    state_next    = S_WAIT_DONE;
                end
            end
            S_SEND_DATA: begin
                if (!tx_busy && sel_valid) begin
                    tx_start_next  = 1'b1;
                    tx_data_next   = sel_data;
                    req_ready_next = NUM_REQ'(1) << grant_reg;
                    csum_next      = csum_reg ^ sel_data;
                    len_next       = len_reg + LEN_W'(1);
                    state_next     = S_WAIT_DONE;
                    if (sel_last || (len_reg == LEN_W'(MAX_LEN - 1))) begin
                        // Remember a forced cut so len_err can ride on the csum start.
                        ovf_next = !sel_last;
                        ret_next = S_SEND_CSUM;
                    end else begin
                        ret_next = S_SEND_DATA;
                    end
                end
            end
            S_SEND_CSUM: begin
                if (!tx_busy) begin
                    tx_start_next = 1'b1;
                    tx_data_next  = csum_reg;
                    len_err_next  = ovf_reg;
                    ret_next      = S_IDLE;
                    state_next    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    state_next = ret_reg;
                    if (ret_reg == S_IDLE) begin
                        frame_done_next = 1'b1;
                        active_next     = 1'b0;
                        ptr_next        = (grant_reg == ID_W'(NUM_REQ - 1)) ? '0
                                                                            : grant_reg + ID_W'(1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign req_ready  = req_ready_reg;
    assign tx_start   = tx_start_reg;
    assign tx_data    = tx_data_reg;
    assign active     = active_reg;
    assign grant_id   = grant_reg;
    assign frame_done = frame_done_reg;
    assign len_err    = len_err_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
// Directed bench: requester queues and a serializer model drive the DUT;
// every wire byte, grant order and pulse is checked against hand values.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int MAX_LEN = 4;
    localparam int SER_CYC = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 active;
    logic [2:0]           grant_id;
    logic                 frame_done;
    logic                 len_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] q_data [NUM_REQ][$];
    bit         q_last [NUM_REQ][$];
    logic [7:0] wire_q[$];
    logic [7:0] exp_q[$];
    logic [2:0] grant_q[$];
    int         fd_cnt = 0;
    int         le_cnt = 0;
    int         done_gap = 100;
    int         ser_cnt = 0;
    bit         gap_chk_en = 1'b1;
    bit         active_prev = 1'b0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .active     (active),
        .grant_id   (grant_id),
        .frame_done (frame_done),
        .len_err    (len_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_wire(input string tag);
        chk({tag, "_nbytes"}, wire_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < wire_q.size(); k++)
            chk($sformatf("%s_byte%0d", tag, k), wire_q[k], exp_q[k]);
        wire_q.delete();
    endtask

    task automatic wait_frames(input int target, input int budget);
        int c;
        c = 0;
        while (fd_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("frame_wait_timeout", (fd_cnt >= target), 1);
    endtask

    task automatic push(input int id, input logic [7:0] b, input bit last);
        q_data[id].push_back(b);
        q_last[id].push_back(last);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_start"},   tx_start,   0);
        chk({tag, "_tx_data"},    tx_data,    0);
        chk({tag, "_active"},     active,     0);
        chk({tag, "_grant_id"},   grant_id,   0);
        chk({tag, "_req_ready"},  req_ready,  0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_len_err"},    len_err,    0);
    endtask

    // Serializer model plus output monitor.
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_busy = 1'b0; tx_done = 1'b0; ser_cnt = 0;
                active_prev = 1'b0; done_gap = 100;
            end else begin
                if (done_gap < 100) done_gap++;
                if (active && !active_prev) begin
                    chk("sync_start_with_active", tx_start, 1);
                    grant_q.push_back(grant_id);
                end
                if (frame_done) begin
                    fd_cnt++;
                    $display("[%0t] frame_done grant=%0d", $time, grant_id);
                end
                if (len_err) begin
                    le_cnt++;
                    chk("len_err_with_start", tx_start, 1);
                end
                tx_done = 1'b0;
                if (tx_start) begin
                    chk("start_while_busy", tx_busy, 0);
                    if (gap_chk_en && active_prev) chk("done_to_start_gap", done_gap, 2);
                    wire_q.push_back(tx_data);
                    tx_busy = 1'b1;
                    ser_cnt = SER_CYC;
                end else if (tx_busy) begin
                    ser_cnt--;
                    if (ser_cnt == 0) begin
                        tx_busy  = 1'b0;
                        tx_done  = 1'b1;
                        done_gap = 0;
                    end
                end
                active_prev = active;
            end
        end
    end

    // Requester models: present queue heads, pop on req_ready.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            if (!rst && req_ready != '0) begin
                chk("ready_only_granted", req_ready, 32'(1) << grant_id);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_ready[i] && q_data[i].size() > 0) begin
                        void'(q_data[i].pop_front());
                        void'(q_last[i].pop_front());
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (q_data[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = q_data[i][0];
                    req_last[i]        = q_last[i][0];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Contention: requesters 0 and 2 valid from reset.
        push(0, 8'h0A, 1'b1);
        push(0, 8'h0B, 1'b1);
        push(2, 8'h2C, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        wait_frames(3, 600);
        exp_q = '{8'hA5, 8'h00, 8'h0A, 8'h0A,
                  8'hA5, 8'h02, 8'h2C, 8'h2E,
                  8'hA5, 8'h00, 8'h0B, 8'h0B};
        cmp_wire("contention");
        chk("contention_ngrants", grant_q.size(), 3);
        if (grant_q.size() == 3) begin
            chk("contention_grant0", grant_q[0], 0);
            chk("contention_grant1", grant_q[1], 2);
            chk("contention_grant2", grant_q[2], 0);
        end
        grant_q.delete();

        // Single frame from requester 1.
        fd_cnt = 0; le_cnt = 0;
        push(1, 8'h10, 1'b0);
        push(1, 8'h20, 1'b1);
        wait_frames(1, 300);
        repeat (5) @(negedge clk);
        exp_q = '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h31};
        cmp_wire("single");
        chk("single_frame_done_cnt", fd_cnt, 1);
        chk("single_len_err_cnt", le_cnt, 0);
        chk("single_active_low", active, 0);

        // Overflow at MAX_LEN = 4: six bytes, only the sixth is last.
        fd_cnt = 0; le_cnt = 0; grant_q.delete();
        push(3, 8'h30, 1'b0);
        push(3, 8'h31, 1'b0);
        push(3, 8'h32, 1'b0);
        push(3, 8'h33, 1'b0);
        push(3, 8'h34, 1'b0);
        push(3, 8'h35, 1'b1);
        wait_frames(2, 600);
        exp_q = '{8'hA5, 8'h03, 8'h30, 8'h31, 8'h32, 8'h33, 8'h03,
                  8'hA5, 8'h03, 8'h34, 8'h35, 8'h02};
        cmp_wire("overflow");
        chk("overflow_len_err_cnt", le_cnt, 1);
        chk("overflow_ngrants", grant_q.size(), 2);
        grant_q.delete();

        // Stall: requester 1 runs dry for 50 cycles between bytes.
        fd_cnt = 0; le_cnt = 0;
        gap_chk_en = 1'b0;
        push(1, 8'h11, 1'b0);
        c = 0;
        while (q_data[1].size() > 0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("stall_first_byte_taken", q_data[1].size(), 0);
        repeat (50) @(negedge clk);
        chk("stall_no_start_in_gap", wire_q.size(), 3);
        chk("stall_still_active", active, 1);
        push(1, 8'h22, 1'b1);
        wait_frames(1, 300);
        exp_q = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h32};
        cmp_wire("stall");
        gap_chk_en = 1'b1;
        grant_q.delete();

        // Reset during the 2nd payload byte of requester 2 (ptr is 2 here).
        fd_cnt = 0; le_cnt = 0;
        push(2, 8'h40, 1'b0);
        push(2, 8'h41, 1'b0);
        push(2, 8'h42, 1'b1);
        c = 0;
        while (wire_q.size() < 4 && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("midframe_reached_byte2", wire_q.size(), 4);
        rst = 1'b1;
        q_data[2].delete(); q_last[2].delete();
        push(2, 8'h50, 1'b1);
        push(0, 8'h60, 1'b1);
        repeat (3) @(negedge clk);
        chk_reset_outputs("midreset");
        chk("midreset_no_pulses", fd_cnt + le_cnt, 0);
        wire_q.delete(); grant_q.delete();
        rst = 1'b0;
        wait_frames(2, 600);
        exp_q = '{8'hA5, 8'h00, 8'h60, 8'h60,
                  8'hA5, 8'h02, 8'h50, 8'h52};
        cmp_wire("after_reset");
        chk("after_reset_len_err_cnt", le_cnt, 0);
        chk("after_reset_ngrants", grant_q.size(), 2);
        if (grant_q.size() == 2) begin
            chk("after_reset_grant0", grant_q[0], 0);
            chk("after_reset_grant1", grant_q[1], 2);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
